ling_mw_add_seq: RTL and testbench

- Multi-word adder sequencer built around one shared 8-bit Ling adder core. The core has no carry-in and no carry-out.
- Accepts NWORDS x 8-bit operands plus a carry-in over a valid/ready handshake.
- Walks the words LSB-first through the core and returns the full-width sum, carry-out and the number of compute cycles used.
- Sits between the wider datapath and the 8-bit core; it is the only master of that core.

---
 rtl/ling_pkg.sv | 25 ++
 rtl/ling_mw_add_seq_j8.sv | 32 +++
 rtl/ling_mw_add_seq.sv | 159 +++++++++++++++
 tb/tb_ling_mw_add_seq.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ling_pkg.sv
// Shared types and helpers for the multi-word Ling adder sequencer.
// Holds the word width, increment constant, FSM states and carry-generate.
package ling_pkg;

    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] INC_CONST = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        INC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Carry out of an 8-bit add rebuilt from the operand MSBs and the sum MSB
    function automatic logic byte_gen(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic [WORD_W-1:0] s
    );
        return (a[WORD_W-1] & b[WORD_W-1])
             | ((a[WORD_W-1] | b[WORD_W-1]) & ~s[WORD_W-1]);
    endfunction

endpackage

// File: rtl/ling_mw_add_seq_j8.sv
// 8-bit Ling adder core: no carry-in, no carry-out.
// Pseudo-carry h[i] = g[i] | t[i-1]&h[i-1]; real carry c[i] = t[i]&h[i].
module J8_adder
    import ling_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] s
);

    logic [WORD_W-2:0] g;
    logic [WORD_W-2:0] t;
    logic [WORD_W-1:0] x;
    logic [WORD_W-2:0] h;

    always_comb begin
        g = a[WORD_W-2:0] & b[WORD_W-2:0];
        t = a[WORD_W-2:0] | b[WORD_W-2:0];
        x = a ^ b;
        h = '0;
        s = '0;
        h[0] = g[0];
        s[0] = x[0];
        for (int i = 1; i < WORD_W - 1; i++) begin
            h[i] = g[i] | (t[i-1] & h[i-1]);
        end
        for (int i = 1; i < WORD_W; i++) begin
            s[i] = x[i] ^ (t[i-1] & h[i-1]);
        end
    end

endmodule

// File: rtl/ling_mw_add_seq.sv
// Multi-word adder sequencer: walks NWORDS bytes LSB-first through one
// carry-less 8-bit Ling core, spending an extra INC cycle per carried word.
module ling_mw_add_seq
    import ling_pkg::*;
#(
    parameter int NWORDS = 4,
    parameter int CW     = $clog2(2*NWORDS+1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W*NWORDS-1:0] in_a,
    input  logic [WORD_W*NWORDS-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W*NWORDS-1:0] out_sum,
    output logic                     out_cout,
    output logic [CW-1:0]            out_cycles,
    output logic                     busy
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    state_t state;
    state_t state_nxt;

    logic [NWORDS-1:0][WORD_W-1:0] a_w;
    logic [NWORDS-1:0][WORD_W-1:0] b_w;
    logic [NWORDS-1:0][WORD_W-1:0] sum_w;
    logic [NWORDS-1:0][WORD_W-1:0] sum_nxt;
    logic [IW-1:0]                 idx;
    logic                          carry;
    logic                          carry_nxt;
    logic [CW-1:0]                 cnt;
    logic [WORD_W-1:0]             s_reg;
    logic                          g_reg;

    logic [WORD_W-1:0] core_a;
    logic [WORD_W-1:0] core_b;
    logic [WORD_W-1:0] core_s;
    logic              gen;
    logic              last;
    logic              wr_en;

    J8_adder u_core (
        .a (core_a),
        .b (core_b),
        .s (core_s)
    );

    assign last = (idx == IW'(NWORDS - 1));
    assign gen  = byte_gen(a_w[idx], b_w[idx], core_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = ADD;
            ADD: begin
                if (carry) begin
                    state_nxt = INC;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            INC:  state_nxt = last ? DONE : ADD;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == ADD) || (state == INC);
    end

    // Core inputs stay at zero outside compute states to keep it quiet
    always_comb begin
        core_a = '0;
        core_b = '0;
        if (state == ADD) begin
            core_a = a_w[idx];
            core_b = b_w[idx];
        end else if (state == INC) begin
            core_a = s_reg;
            core_b = INC_CONST;
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        carry_nxt = carry;
        if (state == ADD && !carry) begin
            wr_en     = 1'b1;
            carry_nxt = gen;
        end else if (state == INC) begin
            wr_en     = 1'b1;
            carry_nxt = g_reg | (s_reg == 8'hFF);
        end
        sum_nxt = sum_w;
        if (wr_en) begin
            sum_nxt[idx] = core_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_w        <= '0;
            b_w        <= '0;
            sum_w      <= '0;
            idx        <= '0;
            carry      <= 1'b0;
            cnt        <= '0;
            s_reg      <= '0;
            g_reg      <= 1'b0;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_cycles <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_w   <= in_a;
                b_w   <= in_b;
                sum_w <= '0;
                carry <= in_cin;
                idx   <= '0;
                cnt   <= '0;
            end
            if (busy) begin
                cnt   <= cnt + CW'(1);
                sum_w <= sum_nxt;
                carry <= carry_nxt;
                if (wr_en && !last) begin
                    idx <= idx + IW'(1);
                end
            end
            if (state == ADD && carry) begin
                s_reg <= core_s;
                g_reg <= gen;
            end
            // Results only move when the last word completes
            if (busy && state_nxt == DONE) begin
                out_sum    <= sum_nxt;
                out_cout   <= carry_nxt;
                out_cycles <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ling_mw_add_seq.sv
// Directed bench for ling_mw_add_seq with hand-computed vectors
// and a small reference model for the back-to-back stream.
module tb_ling_mw_add_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic [3:0]  out_cycles;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ling_mw_add_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_cout   (out_cout),
        .out_cycles (out_cycles),
        .busy       (busy)
    );

    function automatic void model(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        cin,
        output logic [31:0] s,
        output logic        co,
        output logic [3:0]  cy
    );
        logic [32:0] t;
        logic [8:0]  w;
        logic        c;
        t  = {1'b0, a} + {1'b0, b} + 33'(cin);
        s  = t[31:0];
        co = t[32];
        c  = cin;
        cy = 4'd0;
        for (int i = 0; i < 4; i++) begin
            cy = cy + (c ? 4'd2 : 4'd1);
            w  = 9'(a[i*8 +: 8]) + 9'(b[i*8 +: 8]) + 9'(c);
            c  = w[8];
        end
    endfunction

    // Accept one operation and wait for out_valid; lat counts edges after accept
    task automatic run_op(
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        cin,
        output int          lat,
        output bit          ok
    );
        int w;
        w  = 0;
        ok = 1'b1;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) ok = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_sum !== 32'h0 || out_cout !== 1'b0 || out_cycles !== 4'd0) begin
            failures++;
            $display("FAIL reset: rdy=%b vld=%b busy=%b sum=%h cout=%b cyc=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, out_sum, out_cout, out_cycles);
        end
    endtask

    task automatic test_basic();
        logic [31:0] va [3] = '{32'h00000001, 32'h000000FF, 32'hFFFFFFFF};
        logic [31:0] vb [3] = '{32'h00000002, 32'h00000001, 32'h00000000};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] es [3] = '{32'h00000003, 32'h00000100, 32'h00000000};
        logic        ec [3] = '{1'b0, 1'b0, 1'b1};
        logic [3:0]  ey [3] = '{4'd4, 4'd5, 4'd8};
        int lat;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], vc[i], lat, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL basic%0d timeout: out_valid=%b want 1", i, out_valid);
            end
            checks++;
            if (out_sum !== es[i]) begin
                failures++;
                $display("FAIL basic%0d sum: got %h want %h", i, out_sum, es[i]);
            end
            checks++;
            if (out_cout !== ec[i]) begin
                failures++;
                $display("FAIL basic%0d cout: got %b want %b", i, out_cout, ec[i]);
            end
            checks++;
            if (out_cycles !== ey[i]) begin
                failures++;
                $display("FAIL basic%0d cycles: got %0d want %0d", i, out_cycles, ey[i]);
            end
            checks++;
            if (lat !== int'(ey[i])) begin
                failures++;
                $display("FAIL basic%0d latency: got %0d want %0d", i, lat, ey[i]);
            end
            handshake();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== es[i]) begin
                failures++;
                $display("FAIL basic%0d post: vld=%b rdy=%b sum=%h want 0 1 %h",
                         i, out_valid, in_ready, out_sum, es[i]);
            end
        end
    endtask

    task automatic test_hold();
        int lat;
        bit ok;
        run_op(32'h80000000, 32'h80000000, 1'b0, lat, ok);
        checks++;
        if (!ok || out_sum !== 32'h0 || out_cout !== 1'b1 || out_cycles !== 4'd4) begin
            failures++;
            $display("FAIL hold_first: ok=%b sum=%h cout=%b cyc=%0d want 1 0 1 4",
                     ok, out_sum, out_cout, out_cycles);
        end
        // Stray upstream traffic during DONE must be ignored
        in_a     = 32'h12345678;
        in_b     = 32'h11111111;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 32'h0 ||
                out_cout !== 1'b1 || out_cycles !== 4'd4) begin
                failures++;
                $display("FAIL hold%0d: vld=%b rdy=%b sum=%h cout=%b cyc=%0d want 1 0 0 1 4",
                         i, out_valid, in_ready, out_sum, out_cout, out_cycles);
            end
        end
        in_valid = 1'b0;
        handshake();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 32'h0 || out_cout !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: vld=%b rdy=%b sum=%h cout=%b want 0 1 0 1",
                     out_valid, in_ready, out_sum, out_cout);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_single: vld=%b busy=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        bit ok;
        bit seen;
        in_a     = 32'hFFFFFFFF;
        in_b     = 32'h00000000;
        in_cin   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
            out_sum !== 32'h0 || out_cout !== 1'b0 || out_cycles !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid state: rdy=%b vld=%b busy=%b sum=%h cout=%b cyc=%0d want 1 0 0 0 0 0",
                     in_ready, out_valid, busy, out_sum, out_cout, out_cycles);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_mid pulse: out_valid seen=1 want 0");
        end
        run_op(32'h12345678, 32'h11111111, 1'b0, lat, ok);
        checks++;
        if (!ok || out_sum !== 32'h23456789 || out_cout !== 1'b0 || out_cycles !== 4'd4) begin
            failures++;
            $display("FAIL rst_mid after: ok=%b sum=%h cout=%b cyc=%0d want 1 23456789 0 4",
                     ok, out_sum, out_cout, out_cycles);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [31:0] qs [$];
        logic        qc [$];
        logic [3:0]  qy [$];
        logic [31:0] es;
        logic        ec;
        logic [3:0]  ey;
        logic [31:0] ra [2] = '{32'hFFFFFFFF, 32'h00FF00FF};
        logic [31:0] rb [2] = '{32'h00000000, 32'h00010001};
        bit accept;
        bit prev_accept;
        int sent;
        int got;
        int cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        prev_accept = 1'b0;
        out_ready = 1'b1;
        in_a      = ra[0];
        in_b      = rb[0];
        in_cin    = 1'b1;
        in_valid  = 1'b1;
        while (got < 10 && cyc < 1000) begin
            checks++;
            if (in_ready !== !(busy || out_valid) || (prev_accept && in_ready !== 1'b0)) begin
                failures++;
                $display("FAIL b2b ready: rdy=%b busy=%b vld=%b prev_acc=%b",
                         in_ready, busy, out_valid, prev_accept);
            end
            if (out_valid) begin
                es = qs.pop_front();
                ec = qc.pop_front();
                ey = qy.pop_front();
                checks++;
                if (out_sum !== es || out_cout !== ec || out_cycles !== ey) begin
                    failures++;
                    $display("FAIL b2b%0d result: sum=%h cout=%b cyc=%0d want %h %b %0d",
                             got, out_sum, out_cout, out_cycles, es, ec, ey);
                end
                got++;
            end
            accept = in_ready && in_valid;
            if (accept) begin
                model(in_a, in_b, in_cin, es, ec, ey);
                qs.push_back(es);
                qc.push_back(ec);
                qy.push_back(ey);
            end
            @(posedge clk); #1;
            cyc++;
            prev_accept = accept;
            if (accept) begin
                sent++;
                if (sent < 2) begin
                    in_a   = ra[sent];
                    in_b   = rb[sent];
                    in_cin = 1'b0;
                end else if (sent < 10) begin
                    in_a   = $urandom;
                    in_b   = $urandom;
                    in_cin = 1'($urandom_range(1));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (got < 10) begin
            failures++;
            $display("FAIL b2b timeout: got %0d results want 10", got);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
